// File: rtl/mcu_pkg.sv
// Shared opcodes, FSM state encoding and decode helpers for the accumulator MCU.
package mcu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_MUL = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_IN  = 4'hB;
    localparam logic [3:0] OP_OUT = 4'hC;
    localparam logic [3:0] OP_LDI = 4'hD;
    localparam logic [3:0] OP_STH = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    function automatic logic is_mem_op(input logic [3:0] op);
        return op inside {OP_LDA, OP_STA, OP_STH, OP_ADD, OP_SUB,
                          OP_AND, OP_OR, OP_XOR, OP_MUL};
    endfunction

    function automatic logic is_store_op(input logic [3:0] op);
        return (op == OP_STA) || (op == OP_STH);
    endfunction

endpackage

// File: rtl/mcu_if.sv
// Program-ROM and data-RAM request/acknowledge buses of the MCU core.
interface mcu_if #(
    parameter int DW = 16,
    parameter int AW = 8
);
    localparam int IW = 4 + AW;

    logic          rom_req;
    logic [AW-1:0] rom_addr;
    logic          rom_ack;
    logic [IW-1:0] rom_data;
    logic          ram_req;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_ack;
    logic [DW-1:0] ram_rdata;

    modport master (
        output rom_req, rom_addr, ram_req, ram_we, ram_addr, ram_wdata,
        input  rom_ack, rom_data, ram_ack, ram_rdata
    );

    modport slave (
        input  rom_req, rom_addr, ram_req, ram_we, ram_addr, ram_wdata,
        output rom_ack, rom_data, ram_ack, ram_rdata
    );
endinterface

// File: rtl/mcu_alu.sv
// Combinational ALU: result, high product half and carry/borrow from opcode, ACC_L and RAM data.
module mcu_alu
    import mcu_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [3:0]    op_i,
    input  logic [DW-1:0] acc_i,
    input  logic [DW-1:0] data_i,
    output logic [DW-1:0] res_o,
    output logic [DW-1:0] hi_o,
    output logic          c_o
);
    logic [DW:0]     sum;
    logic [DW:0]     diff;
    logic [2*DW-1:0] prod;

    always_comb begin
        sum   = {1'b0, acc_i} + {1'b0, data_i};
        // top bit of the widened difference is the borrow
        diff  = {1'b0, acc_i} - {1'b0, data_i};
        prod  = {{DW{1'b0}}, acc_i} * {{DW{1'b0}}, data_i};
        res_o = data_i;
        hi_o  = '0;
        c_o   = 1'b0;
        case (op_i)
            OP_ADD:  {c_o, res_o} = sum;
            OP_SUB:  {c_o, res_o} = diff;
            OP_AND:  res_o = acc_i & data_i;
            OP_OR:   res_o = acc_i | data_i;
            OP_XOR:  res_o = acc_i ^ data_i;
            OP_MUL:  {hi_o, res_o} = prod;
            default: res_o = data_i;
        endcase
    end
endmodule

// File: rtl/mcu_core.sv
// Multi-cycle accumulator MCU: fetch/exec/mem FSM, double-width ACC, Z/C flags, output ports.
// state   | meaning
// FETCH   | rom_req high at PC, wait for rom_ack, latch IR, PC+1
// EXEC    | retire register/jump/port ops, or launch a RAM access
// MEM     | ram_req held stable until ram_ack, then write back ACC/flags
// HALT    | idle with no requests until reset
module mcu_core
    import mcu_pkg::*;
#(
    parameter int DW    = 16,
    parameter int AW    = 8,
    parameter int N_OUT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    mcu_if.master               bus,
    input  logic [DW-1:0]       port_in_i,
    output logic [N_OUT*DW-1:0] port_out_o,
    output logic [DW-1:0]       acc_lo_o,
    output logic [DW-1:0]       acc_hi_o,
    output logic [AW-1:0]       pc_dbg_o,
    output logic [4+AW-1:0]     ir_dbg_o,
    output logic [1:0]          flags_dbg_o,
    output logic                halted_o
);
    localparam int IW = 4 + AW;

    state_t                    state_q;
    logic [AW-1:0]             pc_q;
    logic [IW-1:0]             ir_q;
    logic [DW-1:0]             acc_l_q;
    logic [DW-1:0]             acc_h_q;
    logic                      z_q;
    logic                      c_q;
    logic [N_OUT-1:0][DW-1:0]  port_q;
    logic                      ram_we_q;
    logic [DW-1:0]             ram_wdata_q;

    logic [3:0]    op;
    logic [AW-1:0] arg;
    logic [DW-1:0] imm;
    logic [DW-1:0] alu_res;
    logic [DW-1:0] alu_hi;
    logic          alu_c;

    assign op  = ir_q[IW-1 -: 4];
    assign arg = ir_q[AW-1:0];
    assign imm = DW'(arg);

    mcu_alu #(.DW(DW)) u_alu (
        .op_i   (op),
        .acc_i  (acc_l_q),
        .data_i (bus.ram_rdata),
        .res_o  (alu_res),
        .hi_o   (alu_hi),
        .c_o    (alu_c)
    );

    // gated with rst_n so an in-flight fetch request drops the instant reset asserts
    assign bus.rom_req   = (state_q == S_FETCH) && rst_n;
    assign bus.rom_addr  = pc_q;
    assign bus.ram_req   = (state_q == S_MEM);
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = arg;
    assign bus.ram_wdata = ram_wdata_q;

    assign port_out_o  = port_q;
    assign acc_lo_o    = acc_l_q;
    assign acc_hi_o    = acc_h_q;
    assign pc_dbg_o    = pc_q;
    assign ir_dbg_o    = ir_q;
    assign flags_dbg_o = {c_q, z_q};
    assign halted_o    = (state_q == S_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            ir_q        <= '0;
            acc_l_q     <= '0;
            acc_h_q     <= '0;
            z_q         <= 1'b1;
            c_q         <= 1'b0;
            port_q      <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (bus.rom_ack) begin
                        ir_q    <= bus.rom_data;
                        pc_q    <= pc_q + AW'(1);
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state_q <= S_FETCH;
                    if (is_mem_op(op)) begin
                        state_q     <= S_MEM;
                        ram_we_q    <= is_store_op(op);
                        ram_wdata_q <= (op == OP_STH) ? acc_h_q : acc_l_q;
                    end
                    case (op)
                        OP_JMP: pc_q <= arg;
                        OP_JZ:  if (z_q) pc_q <= arg;
                        OP_IN: begin
                            acc_l_q <= port_in_i;
                            z_q     <= (port_in_i == '0);
                        end
                        OP_OUT: begin
                            for (int p = 0; p < N_OUT; p++) begin
                                if (32'(arg) == 32'(p)) port_q[p] <= acc_l_q;
                            end
                        end
                        OP_LDI: begin
                            acc_l_q <= imm;
                            z_q     <= (imm == '0);
                        end
                        OP_HLT:  state_q <= S_HALT;
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (bus.ram_ack) begin
                        state_q  <= S_FETCH;
                        ram_we_q <= 1'b0;
                        if (!is_store_op(op)) begin
                            acc_l_q <= alu_res;
                            z_q     <= (alu_res == '0);
                        end
                        if (op == OP_ADD || op == OP_SUB) c_q <= alu_c;
                        if (op == OP_MUL) acc_h_q <= alu_hi;
                    end
                end
                S_HALT: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mcu_core.sv
// Program-driven bench for mcu_core with wait-state memory models and write/fetch scoreboards.
module tb_mcu_core;
    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int N_OUT = 2;
    localparam int IW    = 4 + AW;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [DW-1:0]       port_in = '0;
    logic [N_OUT*DW-1:0] port_out;
    logic [DW-1:0]       acc_lo;
    logic [DW-1:0]       acc_hi;
    logic [AW-1:0]       pc;
    logic [IW-1:0]       ir;
    logic [1:0]          flags;
    logic                halted;

    mcu_if #(.DW(DW), .AW(AW)) bus ();

    mcu_core #(.DW(DW), .AW(AW), .N_OUT(N_OUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.master),
        .port_in_i   (port_in),
        .port_out_o  (port_out),
        .acc_lo_o    (acc_lo),
        .acc_hi_o    (acc_hi),
        .pc_dbg_o    (pc),
        .ir_dbg_o    (ir),
        .flags_dbg_o (flags),
        .halted_o    (halted)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic [IW-1:0] rom [256];
    logic [DW-1:0] ram [256];
    int            rom_wait = 0;
    int            ram_wait = 0;
    int            rc;
    int            dc;
    wr_t           exp_wr[$];
    logic [AW-1:0] exp_fetch[$];
    bit            fetch_en = 1'b0;
    bit            stab_en  = 1'b0;
    int            n_vec = 0;
    int            n_mis = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ROM/RAM responders: ack after the configured number of wait cycles
    initial begin
        wr_t w;
        rc = 0;
        dc = 0;
        bus.rom_ack   = 1'b0;
        bus.rom_data  = '0;
        bus.ram_ack   = 1'b0;
        bus.ram_rdata = '0;
        forever begin
            @(negedge clk);
            bus.rom_ack = 1'b0;
            bus.ram_ack = 1'b0;
            if (bus.rom_req) begin
                rc++;
                if (rc > rom_wait) begin
                    rc = 0;
                    bus.rom_ack  = 1'b1;
                    bus.rom_data = rom[bus.rom_addr];
                    if (fetch_en) begin
                        chk("fetch_pending", exp_fetch.size() > 0, 1);
                        if (exp_fetch.size() > 0) chk("fetch_addr", bus.rom_addr, exp_fetch.pop_front());
                    end
                end
            end else begin
                rc = 0;
            end
            if (bus.ram_req) begin
                dc++;
                if (dc > ram_wait) begin
                    dc = 0;
                    bus.ram_ack   = 1'b1;
                    bus.ram_rdata = ram[bus.ram_addr];
                    if (bus.ram_we) begin
                        chk("wr_pending", exp_wr.size() > 0, 1);
                        if (exp_wr.size() > 0) begin
                            w = exp_wr.pop_front();
                            chk("wr_addr", bus.ram_addr, w.a);
                            chk("wr_data", bus.ram_wdata, w.d);
                        end
                        ram[bus.ram_addr] = bus.ram_wdata;
                    end
                end
            end else begin
                dc = 0;
            end
        end
    end

    // requests must hold address/data steady until acknowledged
    logic          p_rom_req, p_rom_ack, p_ram_req, p_ram_ack, p_ram_we;
    logic [AW-1:0] p_rom_addr, p_ram_addr;
    logic [DW-1:0] p_ram_wdata;
    initial begin
        p_rom_req = 1'b0;
        p_ram_req = 1'b0;
        p_rom_ack = 1'b0;
        p_ram_ack = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (stab_en && p_rom_req && !p_rom_ack) begin
                chk("rom_req_hold", bus.rom_req, 1);
                chk("rom_addr_hold", bus.rom_addr, p_rom_addr);
            end
            if (stab_en && p_ram_req && !p_ram_ack) begin
                chk("ram_req_hold", bus.ram_req, 1);
                chk("ram_addr_hold", bus.ram_addr, p_ram_addr);
                chk("ram_we_hold", bus.ram_we, p_ram_we);
                chk("ram_wdata_hold", bus.ram_wdata, p_ram_wdata);
            end
            p_rom_req   = bus.rom_req;
            p_rom_ack   = bus.rom_ack;
            p_rom_addr  = bus.rom_addr;
            p_ram_req   = bus.ram_req;
            p_ram_ack   = bus.ram_ack;
            p_ram_addr  = bus.ram_addr;
            p_ram_we    = bus.ram_we;
            p_ram_wdata = bus.ram_wdata;
        end
    end

    task automatic enter_reset();
        rst_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            rom[i] = 12'hF00;
            ram[i] = '0;
        end
        exp_wr.delete();
        exp_fetch.delete();
        rom_wait = 0;
        ram_wait = 0;
    endtask

    task automatic start(output int c0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        c0 = cyc;
    endtask

    task automatic wait_halt(input int max);
        int n = 0;
        while (!halted && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("halt_reached", halted, 1);
        chk("wr_drained", exp_wr.size(), 0);
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_wr.push_back(w);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            c0;
        int            n;
        int            reqs;
        logic [31:0]   prod;
        logic [DW-1:0] v;

        // reset values, then reset asserted mid-fetch
        enter_reset();
        rom_wait = 5;
        @(negedge clk);
        chk("rst_rom_req", bus.rom_req, 0);
        chk("rst_ram_req", bus.ram_req, 0);
        chk("rst_pc", pc, 0);
        chk("rst_ir", ir, 0);
        chk("rst_acc", {acc_hi, acc_lo}, 0);
        chk("rst_port", port_out, 0);
        chk("rst_flags", flags, 2'b01);
        chk("rst_halted", halted, 0);
        start(c0);
        @(negedge clk);
        @(negedge clk);
        chk("fetch_req", bus.rom_req, 1);
        chk("fetch_addr0", bus.rom_addr, 0);
        #1 rst_n = 1'b0;
        #1 chk("rst_drops_req", bus.rom_req, 0);
        chk("rst_mid_pc", pc, 0);

        // add and output: LDI 5; STA 10; LDI 7; ADD 10; OUT 1; JZ 50 (not taken); HLT
        enter_reset();
        rom[0] = 12'hD05; rom[1] = 12'h210; rom[2] = 12'hD07;
        rom[3] = 12'h310; rom[4] = 12'hC01; rom[5] = 12'hA50;
        push_wr(8'h10, 16'h0005);
        start(c0);
        n = 0;
        while (port_out[31:16] == '0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("out_latency", cyc - c0, 2 + 3 + 2 + 3 + 2);
        chk("out_port1", port_out[31:16], 16'h0005 + 16'h0007);
        chk("out_port0", port_out[15:0], 0);
        wait_halt(50);
        chk("t2_pc", pc, 7);
        chk("t2_flags", flags, 2'b00);

        // carry-out to zero, then JZ taken to 0x40
        enter_reset();
        ram[8'h20] = 16'hFFFF;
        rom[0] = 12'hD01; rom[1] = 12'h320; rom[2] = 12'hA40;
        start(c0);
        wait_halt(50);
        chk("t3_acc", acc_lo, 0);
        chk("t3_flags", flags, 2'b11);
        chk("t3_pc", pc, 8'h41);

        // full-width multiply, high and low halves stored
        enter_reset();
        ram[8'h21] = 16'h1234;
        rom[0] = 12'hDFF; rom[1] = 12'h821; rom[2] = 12'hE30; rom[3] = 12'h231;
        prod = 32'h0000_00FF * 32'h0000_1234;
        push_wr(8'h30, prod[31:16]);
        push_wr(8'h31, prod[15:0]);
        start(c0);
        wait_halt(60);
        chk("t4_acc", {acc_hi, acc_lo}, prod);
        chk("t4_flags", flags, 2'b00);
        chk("t4_pc", pc, 5);

        // wait states on both memories: LDA 22; ADD 23
        enter_reset();
        rom_wait = 3;
        ram_wait = 2;
        ram[8'h22] = 16'h0040;
        ram[8'h23] = 16'h0003;
        rom[0] = 12'h122; rom[1] = 12'h323;
        stab_en = 1'b1;
        start(c0);
        n = 0;
        while (acc_lo != 16'h0043 && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk("add_latency", cyc - c0, 2 * ((3 + 1) + 1 + (2 + 1)));
        wait_halt(80);
        stab_en = 1'b0;
        chk("t5_acc", acc_lo, 16'h0043);

        // PC wrap through 0xFF, OUT to a nonexistent port, HLT stays quiet
        enter_reset();
        rom[0] = 12'hAFE; rom[8'hFE] = 12'hD09; rom[8'hFF] = 12'h000;
        rom[1] = 12'hC05;
        exp_fetch = '{8'h00, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02};
        fetch_en = 1'b1;
        start(c0);
        wait_halt(60);
        fetch_en = 1'b0;
        chk("fetch_drained", exp_fetch.size(), 0);
        chk("t6_pc", pc, 3);
        chk("t6_acc", acc_lo, 16'h0009);
        chk("t6_port", port_out, 0);
        reqs = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.rom_req || bus.ram_req) reqs++;
        end
        chk("halt_noreq", reqs, 0);
        chk("halt_held", halted, 1);

        // borrow, IN and logic ops; C survives the non-arithmetic ops
        enter_reset();
        port_in = 16'hA5A5;
        ram[8'h24] = 16'h0005;
        ram[8'h27] = 16'h0FF0;
        rom[0]  = 12'hD03; rom[1]  = 12'h424; rom[2]  = 12'h225; rom[3]  = 12'hB00;
        rom[4]  = 12'h226; rom[5]  = 12'h527; rom[6]  = 12'h228; rom[7]  = 12'h727;
        rom[8]  = 12'h229; rom[9]  = 12'h627; rom[10] = 12'h22A; rom[11] = 12'h12B;
        v = 16'h0003 - 16'h0005;
        push_wr(8'h25, v);
        push_wr(8'h26, 16'hA5A5);
        v = 16'hA5A5 & 16'h0FF0;
        push_wr(8'h28, v);
        v = v ^ 16'h0FF0;
        push_wr(8'h29, v);
        v = v | 16'h0FF0;
        push_wr(8'h2A, v);
        start(c0);
        wait_halt(120);
        chk("t7_acc", acc_lo, 0);
        chk("t7_flags", flags, 2'b11);
        chk("t7_pc", pc, 13);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
